// File: rtl/cc_game_pkg.sv
// Shared game constants: FSM state encoding and default level sizing
// used by the level tracker, scoreboard and display blocks.
package cc_game_pkg;

  localparam int LEVELS_DATAWIDTH_DEF = 5;
  localparam int TARGET_LEVEL_DEF     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    WON  = 2'b10
  } cc_state_t;

endpackage

// File: rtl/cc_rise_edge_detect.sv
// 1-bit rising-edge detector: a register keeps the previous sample and
// an event is the input high while the previous sample was low.
module cc_rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= sig;
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/cc_level_tracker.sv
// Registered level counter and win detector for the Frogger game path.
// Optional auto-restart after a win: CC_LEVEL_TRACKER_AUTORESTART_EN.
module cc_level_tracker
  import cc_game_pkg::*;
#(
  parameter int LEVELS_DATAWIDTH = LEVELS_DATAWIDTH_DEF,
  parameter int TARGET_LEVEL     = TARGET_LEVEL_DEF,
  parameter int START_LEVEL      = 0,
  parameter int WIN_HOLD_CYCLES  = 16
) (
  input  logic                        CC_LEVEL_TRACKER_CLOCK_50,
  input  logic                        CC_LEVEL_TRACKER_RESET_InHigh,
  input  logic                        CC_LEVEL_TRACKER_start_InHigh,
  input  logic                        CC_LEVEL_TRACKER_clear_InHigh,
  input  logic                        CC_LEVEL_TRACKER_levelUp_InHigh,
  output logic [LEVELS_DATAWIDTH-1:0] CC_LEVEL_TRACKER_level_Out,
  output logic                        CC_LEVEL_TRACKER_win_OutLow,
  output logic                        CC_LEVEL_TRACKER_winPulse_OutHigh,
  output logic                        CC_LEVEL_TRACKER_playing_OutHigh
);

  localparam int LW = LEVELS_DATAWIDTH;
  localparam int LMAX = (1 << LW) - 1;
  localparam bit PARAMS_OK = (START_LEVEL >= 0)
                          && (TARGET_LEVEL > START_LEVEL)
                          && (TARGET_LEVEL <= LMAX)
                          && (WIN_HOLD_CYCLES >= 1);
  localparam logic [LW-1:0] START_V  = LW'(START_LEVEL);
  localparam logic [LW-1:0] TARGET_V = LW'(TARGET_LEVEL);

  generate
    if (!PARAMS_OK) begin : g_illegal_params
      $error("cc_level_tracker: illegal level parameters");
    end
  endgenerate

  logic clk;
  logic rst;
  logic rise;

  assign clk = CC_LEVEL_TRACKER_CLOCK_50;
  assign rst = CC_LEVEL_TRACKER_RESET_InHigh;

  cc_rise_edge_detect u_level_up_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (CC_LEVEL_TRACKER_levelUp_InHigh),
    .rise (rise)
  );

  cc_state_t       state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic            win_n_q, win_n_d;
  logic            pulse_q, pulse_d;
  logic            play_q, play_d;

`ifdef CC_LEVEL_TRACKER_AUTORESTART_EN
  localparam int HW = $clog2(WIN_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD_CYCLES - 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d = state_q;
    level_d = level_q;
`ifdef CC_LEVEL_TRACKER_AUTORESTART_EN
    hold_d  = '0;
`endif
    if (CC_LEVEL_TRACKER_clear_InHigh) begin
      state_d = IDLE;
      level_d = START_V;
    end else begin
      unique case (state_q)
        IDLE: begin
          level_d = START_V;
          if (CC_LEVEL_TRACKER_start_InHigh) state_d = PLAY;
        end
        PLAY: begin
          if (rise) begin
            level_d = level_q + 1'b1;
            if (level_d == TARGET_V) state_d = WON;
          end
        end
        WON: begin
          level_d = TARGET_V;
`ifdef CC_LEVEL_TRACKER_AUTORESTART_EN
          // Hold counter runs 0..WIN_HOLD_CYCLES-1 while the win shows
          if (hold_q == HOLD_LAST) begin
            state_d = PLAY;
            level_d = START_V;
          end else begin
            hold_d = hold_q + 1'b1;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          level_d = START_V;
        end
      endcase
    end
    win_n_d = (state_d != WON);
    pulse_d = (state_d == WON) && (state_q != WON);
    play_d  = (state_d == PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= START_V;
      win_n_q <= 1'b1;
      pulse_q <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      win_n_q <= win_n_d;
      pulse_q <= pulse_d;
      play_q  <= play_d;
    end
  end

`ifdef CC_LEVEL_TRACKER_AUTORESTART_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  assign CC_LEVEL_TRACKER_level_Out        = level_q;
  assign CC_LEVEL_TRACKER_win_OutLow       = win_n_q;
  assign CC_LEVEL_TRACKER_winPulse_OutHigh = pulse_q;
  assign CC_LEVEL_TRACKER_playing_OutHigh  = play_q;

endmodule
